// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the iterative RISC-V M-extension multiplier/divider array.
// Latches and classifies operands, strobes the array, and resolves divide special cases directly.
module muldiv_ctrl #(
   parameter int MUL_CYCLES = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        kill_i,
   input  logic [31:0] dp_result_i,
   output logic        ready_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o,
   output logic        dp_load_o,
   output logic        dp_step_o,
   output logic        sel_div_o,
   output logic [1:0]  op_mul_o,
   output logic [1:0]  op_div_o,
   output logic        a_neg_o,
   output logic        b_neg_o,
   output logic [31:0] a_mag_o,
   output logic [31:0] b_mag_o
);

   localparam int MAX_C = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic           r_ready, r_busy, r_done, r_load, r_step;
   logic           r_sel_div, r_a_neg, r_b_neg, r_special;
   logic [1:0]     r_op_mul, r_op_div;
   logic [31:0]    r_a_mag, r_b_mag, r_spec_res;

   logic           w_accept, w_is_div, w_div_signed, w_a_signed, w_b_signed;
   logic           w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_special;
   logic [31:0]    w_a_mag, w_b_mag, w_spec_res;

   // Operand classification and special-case detection on the incoming request
   always_comb begin
      w_accept     = start_i & r_ready & ~kill_i;
      w_is_div     = funct3_i[2];
      w_div_signed = ~funct3_i[0];
      w_a_signed   = w_is_div ? w_div_signed : (funct3_i[1:0] != 2'b11);
      w_b_signed   = w_is_div ? w_div_signed : ~funct3_i[1];
      w_a_neg      = rs1_i[31] & w_a_signed;
      w_b_neg      = rs2_i[31] & w_b_signed;
      w_a_mag      = w_a_neg ? (32'd0 - rs1_i) : rs1_i;
      w_b_mag      = w_b_neg ? (32'd0 - rs2_i) : rs2_i;
      w_div_zero   = w_is_div & (rs2_i == 32'd0);
      w_div_ovf    = w_is_div & w_div_signed & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
      w_special    = w_div_zero | w_div_ovf;
      if (w_div_zero) begin
         w_spec_res = funct3_i[1] ? rs1_i : 32'hFFFF_FFFF;
      end else if (w_div_ovf) begin
         w_spec_res = funct3_i[1] ? 32'd0 : 32'h8000_0000;
      end else begin
         w_spec_res = 32'd0;
      end
   end

   // Control FSM with all outputs registered from the next-state decision
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_load     <= 1'b0;
         r_step     <= 1'b0;
         r_sel_div  <= 1'b0;
         r_op_mul   <= 2'b00;
         r_op_div   <= 2'b00;
         r_a_neg    <= 1'b0;
         r_b_neg    <= 1'b0;
         r_a_mag    <= 32'd0;
         r_b_mag    <= 32'd0;
         r_special  <= 1'b0;
         r_spec_res <= 32'd0;
      end else if (kill_i) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_load  <= 1'b0;
         r_step  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_sel_div  <= w_is_div;
                  r_op_mul   <= funct3_i[1:0];
                  r_op_div   <= {funct3_i[1], ~funct3_i[0]};
                  r_a_neg    <= w_a_neg;
                  r_b_neg    <= w_b_neg;
                  r_a_mag    <= w_a_mag;
                  r_b_mag    <= w_b_mag;
                  r_special  <= w_special;
                  r_spec_res <= w_spec_res;
                  r_state    <= w_special ? S_DONE : S_LOAD;
                  r_ready    <= w_special;
                  r_busy     <= ~w_special;
                  r_done     <= w_special;
                  r_load     <= ~w_special;
                  r_step     <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
                  r_load  <= 1'b0;
                  r_step  <= 1'b0;
               end
            end
            S_LOAD: begin
               r_state <= S_RUN;
               r_load  <= 1'b0;
               r_step  <= 1'b1;
               r_cnt   <= r_sel_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
            end
            S_RUN: begin
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  r_step  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_load  <= 1'b0;
               r_step  <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o   = r_ready;
   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign dp_load_o = r_load;
   assign dp_step_o = r_step;
   assign sel_div_o = r_sel_div;
   assign op_mul_o  = r_op_mul;
   assign op_div_o  = r_op_div;
   assign a_neg_o   = r_a_neg;
   assign b_neg_o   = r_b_neg;
   assign a_mag_o   = r_a_mag;
   assign b_mag_o   = r_b_mag;
   // Special ops never touch the array, so their result comes from the latched value
   assign result_o  = r_done ? (r_special ? r_spec_res : dp_result_i) : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic M-extension reference.
module tb_muldiv_ctrl;

   localparam int MULC = 32;
   localparam int DIVC = 32;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  funct3_i = 3'd0;
   logic [31:0] rs1_i = 32'd0;
   logic [31:0] rs2_i = 32'd0;
   logic        kill_i = 1'b0;
   logic [31:0] dp_result_i = 32'd0;
   logic        ready_o, busy_o, done_o, dp_load_o, dp_step_o, sel_div_o, a_neg_o, b_neg_o;
   logic [1:0]  op_mul_o, op_div_o;
   logic [31:0] result_o, a_mag_o, b_mag_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic        exp_special, exp_sel_div, exp_a_neg, exp_b_neg;
   logic [1:0]  exp_op_mul, exp_op_div;
   logic [31:0] exp_res, exp_a_mag, exp_b_mag;
   int          exp_lat;

   muldiv_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .funct3_i(funct3_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .kill_i(kill_i), .dp_result_i(dp_result_i),
      .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
      .dp_load_o(dp_load_o), .dp_step_o(dp_step_o), .sel_div_o(sel_div_o),
      .op_mul_o(op_mul_o), .op_div_o(op_div_o), .a_neg_o(a_neg_o), .b_neg_o(b_neg_o),
      .a_mag_o(a_mag_o), .b_mag_o(b_mag_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Architectural result of an M-extension instruction
   function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      p;
      logic [63:0] pv;
      int          sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'd0, 3'd1: begin p = longint'(sa) * longint'(sb); pv = p; return (f3 == 3'd0) ? pv[31:0] : pv[63:32]; end
         3'd2: begin p = longint'(sa) * longint'({32'd0, b}); pv = p; return pv[63:32]; end
         3'd3: begin pv = {32'd0, a} * {32'd0, b}; return pv[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa % sb;
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bit is_div, a_s, b_s;
      is_div = (f3 >= 3'd4);
      if (is_div) begin
         a_s = (f3 == 3'd4) || (f3 == 3'd6);
         b_s = a_s;
      end else begin
         a_s = (f3 != 3'd3);
         b_s = (f3 == 3'd0) || (f3 == 3'd1);
      end
      exp_sel_div = is_div;
      exp_op_mul  = f3 % 4;
      exp_op_div  = {f3[1], ~f3[0]};
      exp_a_neg   = a_s && (a >= 32'h8000_0000);
      exp_b_neg   = b_s && (b >= 32'h8000_0000);
      exp_a_mag   = exp_a_neg ? (32'd0 - a) : a;
      exp_b_mag   = exp_b_neg ? (32'd0 - b) : b;
      exp_special = is_div && ((b == 32'd0) || (a_s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_res     = md_ref(f3, a, b);
      exp_lat     = exp_special ? 1 : (2 + (is_div ? DIVC : MULC));
   endtask

   // Drive a request at a negedge and pass the accepting edge; inputs are then scrambled
   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      model(f3, a, b);
      check_eq("ready_before_start", {31'd0, ready_o}, 32'd1);
      dp_result_i = exp_special ? $urandom : exp_res;
      start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
      @(posedge clk_i);
      #1;
      start_i = 1'b0; funct3_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
   endtask

   // Full op: returns at the negedge where done_o is seen (or the bound expires)
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit poke);
      int loads, steps, first_load, done_cyc;
      launch(f3, a, b);
      loads = 0; steps = 0; first_load = -1; done_cyc = -1;
      for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
         @(negedge clk_i);
         if (dp_load_o) begin loads++; if (first_load < 0) first_load = c; end
         if (dp_step_o) steps++;
         if (done_o) done_cyc = c;
         if (poke && c == 5) begin
            check_eq("ready_in_run", {31'd0, ready_o}, 32'd0);
            start_i = 1'b1; funct3_i = 3'd4; rs2_i = 32'd0;
         end
         if (c == 6) start_i = 1'b0;
      end
      check_eq("latency", done_cyc, exp_lat);
      check_eq("load_count", loads, exp_special ? 0 : 1);
      if (!exp_special) check_eq("load_cycle", first_load, 1);
      check_eq("step_count", steps, exp_special ? 0 : (exp_sel_div ? DIVC : MULC));
      check_eq("result", result_o, exp_res);
      check_eq("busy_at_done", {31'd0, busy_o}, 32'd0);
      check_eq("sel_div", {31'd0, sel_div_o}, {31'd0, exp_sel_div});
      check_eq("op_mul", {30'd0, op_mul_o}, {30'd0, exp_op_mul});
      check_eq("op_div", {30'd0, op_div_o}, {30'd0, exp_op_div});
      check_eq("a_neg", {31'd0, a_neg_o}, {31'd0, exp_a_neg});
      check_eq("b_neg", {31'd0, b_neg_o}, {31'd0, exp_b_neg});
      check_eq("a_mag", a_mag_o, exp_a_mag);
      check_eq("b_mag", b_mag_o, exp_b_mag);
   endtask

   task automatic gap();
      @(negedge clk_i);
      check_eq("done_one_cycle", {31'd0, done_o}, 32'd0);
      check_eq("ready_idle", {31'd0, ready_o}, 32'd1);
   endtask

   initial begin
      int dones;
      logic [2:0]  f3;
      logic [31:0] a, b;
      #2;
      check_eq("rst_ready", {31'd0, ready_o}, 32'd0);
      check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
      check_eq("rst_done", {31'd0, done_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      check_eq("ready_after_reset", {31'd0, ready_o}, 32'd1);

      do_op(3'd0, 32'd3, 32'hFFFF_FFFB, 1'b0);
      check_eq("mul_b_mag_5", b_mag_o, 32'd5);
      gap();
      do_op(3'd4, 32'd100, 32'd0, 1'b0);            gap();
      do_op(3'd7, 32'd100, 32'd0, 1'b0);            gap();
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); gap();
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); gap();
      do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); gap();
      // back-to-back: second request issued during DONE, extra start poked in RUN
      do_op(3'd1, 32'hFFFF_0000, 32'd12345, 1'b1);
      do_op(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
      gap();

      // kill at RUN cycle 10, with a special-op start in the same cycle
      launch(3'd0, 32'd7, 32'd9);
      repeat (11) @(negedge clk_i);
      check_eq("kill_pre_step", {31'd0, dp_step_o}, 32'd1);
      kill_i = 1'b1; start_i = 1'b1; funct3_i = 3'd4; rs2_i = 32'd0;
      @(posedge clk_i);
      #1;
      kill_i = 1'b0; start_i = 1'b0;
      @(negedge clk_i);
      check_eq("kill_busy", {31'd0, busy_o}, 32'd0);
      check_eq("kill_step", {31'd0, dp_step_o}, 32'd0);
      check_eq("kill_ready", {31'd0, ready_o}, 32'd1);
      dones = 0;
      repeat (40) begin @(negedge clk_i); if (done_o) dones++; end
      check_eq("kill_no_done", dones, 0);

      // asynchronous reset mid-RUN
      launch(3'd4, 32'hFFFF_FFEC, 32'd3);
      repeat (11) @(negedge clk_i);
      #2 reset_i = 1'b0;
      #1;
      check_eq("arst_ctrl", {26'd0, busy_o, ready_o, done_o, dp_step_o, dp_load_o, sel_div_o}, 32'd0);
      check_eq("arst_sign", {28'd0, op_div_o, a_neg_o, b_neg_o}, 32'd0);
      check_eq("arst_a_mag", a_mag_o, 32'd0);
      check_eq("arst_result", result_o, 32'd0);
      @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      check_eq("arst_ready_after", {31'd0, ready_o}, 32'd1);
      check_eq("arst_busy_after", {31'd0, busy_o}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            1: b = 32'd0;
            2: b = b >> $urandom_range(16, 31);
            default: ;
         endcase
         do_op(f3, a, b, ($urandom_range(0, 1) == 1));
         if ($urandom_range(0, 1) == 1) gap();
      end
      gap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
